// File: rtl/btn_conditioner.sv
// Four-channel push-button front end: 2-FF synchronizer, counter debounce,
// registered press/release pulses and optional hold-to-auto-repeat per channel.
module btn_conditioner #(
  parameter int unsigned     N_BTN         = 4,
  parameter int unsigned     DB_CYCLES     = 16,
  parameter int unsigned     REPEAT_DELAY  = 25000000,
  parameter int unsigned     REPEAT_PERIOD = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_EN    = 4'b0110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic [N_BTN-1:0] btn_event
);

  localparam int unsigned CW = $clog2(DB_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StDelay, StRpt} rpt_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_q, rpt_d;
    logic          event_q;
    rpt_state_e    st_q, st_d;
    logic [31:0]   hold_q, hold_d;

    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s2_q != level_q) begin
        if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
          level_d = s2_q;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    // The FSM looks at next-cycle level/press so its registered repeat pulse
    // lines up exactly with the counter reaching the programmed interval.
    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      rpt_d  = 1'b0;
      case (st_q)
        StIdle: begin
          if (press_d && REPEAT_EN[i]) begin
            st_d   = StDelay;
            hold_d = 32'd1;
          end
        end
        StDelay: begin
          if (!level_d) begin
            st_d = StIdle;
          end else if (hold_q == REPEAT_DELAY) begin
            rpt_d  = 1'b1;
            st_d   = StRpt;
            hold_d = 32'd1;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
        StRpt: begin
          if (!level_d) begin
            st_d = StIdle;
          end else if (hold_q == REPEAT_PERIOD) begin
            rpt_d  = 1'b1;
            hold_d = 32'd1;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
        event_q   <= 1'b0;
        st_q      <= StIdle;
        hold_q    <= '0;
      end else begin
        s1_q      <= btn_raw[i];
        s2_q      <= s1_q;
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        rpt_q     <= rpt_d;
        event_q   <= press_d | rpt_d;
        st_q      <= st_d;
        hold_q    <= hold_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = rpt_q;
    assign btn_event[i]   = event_q;
  end

endmodule
